clkbuf_gate_seq: RTL and testbench

- Sequences the enable of a gated, buffered clock tree (clock gate driving a clkbuf_16 fan-out) shared by NREQ requesters.
- Wakes the tree on demand and grants each requester only after a settle interval.
- Gates the tree off after a programmable idle interval.
- Sits in the always-on domain beside the clock-gate cell; its CE output is the gate's enable.

---
 rtl/clkbuf_gate_seq_if.sv | 29 ++
 rtl/clkbuf_gate_seq.sv | 124 ++++++++++++
 tb/tb_clkbuf_gate_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clkbuf_gate_seq_if.sv
// Request/grant bundle between the requesters and the clock-tree enable sequencer.
// Latency: n/a (wires only).
// Backpressure: none; REQ/FORCE are level requests, GNT is the level acknowledge.
// Ports (signals):
//   REQ   [NREQ] per-requester clock request        (master -> slave)
//   FORCE        hold tree on, no grant bit           (master -> slave)
//   CE           clock-gate enable                    (slave -> master)
//   GNT   [NREQ] per-requester clock-valid acknowledge (slave -> master)
//   STATE [2]    sequencer state, CNT [8] debug counter (slave -> master)
interface clkbuf_gate_seq_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] REQ;
  logic            FORCE;
  logic            CE;
  logic [NREQ-1:0] GNT;
  logic [1:0]      STATE;
  logic [7:0]      CNT;

  modport master (
    output REQ, FORCE,
    input  CE, GNT, STATE, CNT
  );

  modport slave (
    input  REQ, FORCE,
    output CE, GNT, STATE, CNT
  );
endinterface

// File: rtl/clkbuf_gate_seq.sv
// Sequences the enable of a gated, buffered clock tree shared by NREQ requesters.
// Latency: CE rises one edge after the first request; GNT follows REQ one cycle after ON.
// Backpressure: none; requests are levels, grants withheld until the tree has settled.
// Ports:
//   CLK  always-on clock, RN asynchronous active-low reset
//   bus  slave side of clkbuf_gate_seq_if (REQ, FORCE in; CE, GNT, STATE, CNT out)
module clkbuf_gate_seq #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16
) (
  input logic               CLK,
  input logic               RN,
  clkbuf_gate_seq_if.slave  bus
);

  // Parameters outside the counter range or requester range are rejected at elaboration.
  if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
    $error("clkbuf_gate_seq: NREQ must be 1..16");
  end
  if (WAKE_CYC < 0 || WAKE_CYC > 255) begin : g_bad_wake
    $error("clkbuf_gate_seq: WAKE_CYC must be 0..255");
  end
  if (IDLE_CYC < 0 || IDLE_CYC > 255) begin : g_bad_idle
    $error("clkbuf_gate_seq: IDLE_CYC must be 0..255");
  end

  localparam logic [7:0] WAKE_LD = 8'(WAKE_CYC);
  localparam logic [7:0] IDLE_LD = 8'(IDLE_CYC);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_WAKE  = 2'b01,
    ST_ON    = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            ce_q, ce_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            any_req;

  // FORCE acts as an extra requester that never receives a grant bit.
  assign any_req = (|bus.REQ) | bus.FORCE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    gnt_d   = '0;
    unique case (state_q)
      ST_OFF: begin
        ce_d = 1'b0;
        if (any_req) begin
          ce_d = 1'b1;
          if (WAKE_LD == 8'd0) begin
            // No settle interval: enable and go straight to granting.
            state_d = ST_ON;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LD;
          end
        end
      end
      ST_WAKE: begin
        // Runs to completion even if requests vanish; ON then falls to DRAIN.
        ce_d = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        ce_d = 1'b1;
        if (any_req) begin
          gnt_d = bus.REQ;
        end else begin
          state_d = ST_DRAIN;
          cnt_d   = IDLE_LD;
        end
      end
      ST_DRAIN: begin
        ce_d = 1'b1;
        // A request on the terminal count still rescues the tree (checked first).
        if (any_req) begin
          state_d = ST_ON;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_OFF;
          ce_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = 8'd0;
        ce_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      ce_q    <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.CE    = ce_q;
  assign bus.GNT   = gnt_q;
  assign bus.STATE = state_q;
  assign bus.CNT   = cnt_q;

endmodule

// File: tb/tb_clkbuf_gate_seq.sv
// Directed bench for clkbuf_gate_seq: instance A (WAKE_CYC=2, IDLE_CYC=3),
// instance B (WAKE_CYC=0, IDLE_CYC=0). Inputs change 1ns after a rising edge,
// outputs are sampled at that same point.
module tb_clkbuf_gate_seq;

  logic CLK;
  logic RN;
  int   total;
  int   bad;

  clkbuf_gate_seq_if #(.NREQ(4)) ifa ();
  clkbuf_gate_seq_if #(.NREQ(4)) ifb ();

  clkbuf_gate_seq #(.NREQ(4), .WAKE_CYC(2), .IDLE_CYC(3)) dut_a (
    .CLK (CLK),
    .RN  (RN),
    .bus (ifa)
  );

  clkbuf_gate_seq #(.NREQ(4), .WAKE_CYC(0), .IDLE_CYC(0)) dut_b (
    .CLK (CLK),
    .RN  (RN),
    .bus (ifb)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RN = 1'b0;
    ifa.REQ = 4'b0000; ifa.FORCE = 1'b0;
    ifb.REQ = 4'b0000; ifb.FORCE = 1'b0;
    #1;
    total++; if (ifa.STATE !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", ifa.STATE); end
    total++; if (ifa.CE !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b want=0", ifa.CE); end
    total++; if (ifa.GNT !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", ifa.GNT); end
    total++; if (ifa.CNT !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", ifa.CNT); end
    tick();
    RN = 1'b1;
  endtask

  // REQ at cycle 0 -> WAKE with CNT 2,1,0 -> ON at cycle 4 -> GNT at cycle 5.
  task automatic test_wake();
    logic [1:0] est  [5];
    logic [7:0] ecnt [5];
    logic [3:0] egnt [5];
    est  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    ecnt = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    egnt = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    total++; if (ifa.STATE !== 2'b00 || ifa.CE !== 1'b0) begin bad++; $display("FAIL wake_c0 state=%b ce=%b want 00/0", ifa.STATE, ifa.CE); end
    ifa.REQ = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ifa.STATE !== est[i]) begin bad++; $display("FAIL wake_state c%0d got=%b want=%b", i + 1, ifa.STATE, est[i]); end
      total++; if (ifa.CE !== 1'b1) begin bad++; $display("FAIL wake_ce c%0d got=%b want=1", i + 1, ifa.CE); end
      total++; if (ifa.CNT !== ecnt[i]) begin bad++; $display("FAIL wake_cnt c%0d got=%0d want=%0d", i + 1, ifa.CNT, ecnt[i]); end
      total++; if (ifa.GNT !== egnt[i]) begin bad++; $display("FAIL wake_gnt c%0d got=%b want=%b", i + 1, ifa.GNT, egnt[i]); end
    end
  endtask

  // From ON drop REQ: DRAIN with CNT 3,2,1,0 then OFF with CE low.
  task automatic test_drain();
    ifa.REQ = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ifa.STATE !== 2'b11) begin bad++; $display("FAIL drain_state d%0d got=%b want=11", i, ifa.STATE); end
      total++; if (ifa.CNT !== 8'(3 - i)) begin bad++; $display("FAIL drain_cnt d%0d got=%0d want=%0d", i, ifa.CNT, 3 - i); end
      total++; if (ifa.CE !== 1'b1 || ifa.GNT !== 4'b0000) begin bad++; $display("FAIL drain_out d%0d ce=%b gnt=%b want 1/0000", i, ifa.CE, ifa.GNT); end
    end
    tick();
    total++; if (ifa.STATE !== 2'b00 || ifa.CE !== 1'b0 || ifa.CNT !== 8'd0) begin bad++; $display("FAIL drain_off state=%b ce=%b cnt=%0d want 00/0/0", ifa.STATE, ifa.CE, ifa.CNT); end
  endtask

  // Request on the DRAIN terminal count returns to ON without a wake interval.
  task automatic test_drain_rescue();
    bit ok;
    ifa.REQ = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (ifa.STATE === 2'b10) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL rescue_reach_on timeout state=%b want=10", ifa.STATE); end
    ifa.REQ = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (ifa.STATE === 2'b11 && ifa.CNT === 8'd0) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL rescue_reach_drain0 timeout state=%b cnt=%0d want 11/0", ifa.STATE, ifa.CNT); end
    ifa.REQ = 4'b0100;
    tick();
    total++; if (ifa.STATE !== 2'b10) begin bad++; $display("FAIL rescue_state got=%b want=10", ifa.STATE); end
    total++; if (ifa.CE !== 1'b1 || ifa.GNT !== 4'b0000) begin bad++; $display("FAIL rescue_out ce=%b gnt=%b want 1/0000", ifa.CE, ifa.GNT); end
    tick();
    total++; if (ifa.GNT !== 4'b0100 || ifa.STATE !== 2'b10) begin bad++; $display("FAIL rescue_gnt gnt=%b state=%b want 0100/10", ifa.GNT, ifa.STATE); end
  endtask

  // Requesters joining/leaving in ON, then FORCE alone holding ON with no grant.
  task automatic test_swap_force();
    ifa.REQ = 4'b0011;
    tick();
    total++; if (ifa.GNT !== 4'b0011) begin bad++; $display("FAIL swap_gnt0 got=%b want=0011", ifa.GNT); end
    ifa.REQ = 4'b0110;
    tick();
    total++; if (ifa.GNT !== 4'b0110) begin bad++; $display("FAIL swap_gnt1 got=%b want=0110", ifa.GNT); end
    total++; if (ifa.STATE !== 2'b10 || ifa.CE !== 1'b1) begin bad++; $display("FAIL swap_hold state=%b ce=%b want 10/1", ifa.STATE, ifa.CE); end
    ifa.REQ = 4'b0000;
    ifa.FORCE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (ifa.STATE !== 2'b10 || ifa.GNT !== 4'b0000 || ifa.CE !== 1'b1) begin bad++; $display("FAIL force_hold f%0d state=%b gnt=%b ce=%b want 10/0000/1", i, ifa.STATE, ifa.GNT, ifa.CE); end
    end
    ifa.FORCE = 1'b0;
  endtask

  // Asynchronous reset mid-WAKE, then restart with REQ held.
  task automatic test_async_reset();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (ifa.STATE === 2'b00) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL areset_reach_off timeout state=%b want=00", ifa.STATE); end
    ifa.REQ = 4'b0001;
    tick();
    tick();
    total++; if (ifa.STATE !== 2'b01 || ifa.CNT !== 8'd1) begin bad++; $display("FAIL areset_pre state=%b cnt=%0d want 01/1", ifa.STATE, ifa.CNT); end
    #2 RN = 1'b0;
    #1;
    total++; if (ifa.STATE !== 2'b00) begin bad++; $display("FAIL areset_state got=%b want=00", ifa.STATE); end
    total++; if (ifa.CE !== 1'b0 || ifa.GNT !== 4'b0000 || ifa.CNT !== 8'd0) begin bad++; $display("FAIL areset_out ce=%b gnt=%b cnt=%0d want 0/0000/0", ifa.CE, ifa.GNT, ifa.CNT); end
    #2 RN = 1'b1;
    tick();
    total++; if (ifa.STATE !== 2'b01 || ifa.CNT !== 8'd2 || ifa.CE !== 1'b1) begin bad++; $display("FAIL areset_restart0 state=%b cnt=%0d ce=%b want 01/2/1", ifa.STATE, ifa.CNT, ifa.CE); end
    tick();
    total++; if (ifa.STATE !== 2'b01 || ifa.CNT !== 8'd1) begin bad++; $display("FAIL areset_restart1 state=%b cnt=%0d want 01/1", ifa.STATE, ifa.CNT); end
    ifa.REQ = 4'b0000;
  endtask

  // WAKE_CYC=0, IDLE_CYC=0: one-cycle FORCE pulse gives OFF->ON->DRAIN->OFF, no grant.
  task automatic test_zero_intervals();
    logic [1:0] est [4];
    logic       ece [4];
    est = '{2'b10, 2'b11, 2'b00, 2'b00};
    ece = '{1'b1, 1'b1, 1'b0, 1'b0};
    total++; if (ifb.STATE !== 2'b00 || ifb.CE !== 1'b0) begin bad++; $display("FAIL zero_c0 state=%b ce=%b want 00/0", ifb.STATE, ifb.CE); end
    ifb.FORCE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ifb.FORCE = 1'b0;
      total++; if (ifb.STATE !== est[i]) begin bad++; $display("FAIL zero_state c%0d got=%b want=%b", i + 1, ifb.STATE, est[i]); end
      total++; if (ifb.CE !== ece[i]) begin bad++; $display("FAIL zero_ce c%0d got=%b want=%b", i + 1, ifb.CE, ece[i]); end
      total++; if (ifb.GNT !== 4'b0000 || ifb.CNT !== 8'd0) begin bad++; $display("FAIL zero_gnt c%0d gnt=%b cnt=%0d want 0000/0", i + 1, ifb.GNT, ifb.CNT); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_wake();
    test_drain();
    test_drain_rescue();
    test_swap_force();
    test_async_reset();
    test_zero_intervals();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
